// File: rtl/sonar_varredura_ctrl.sv
// ---------------------------------------------------------------------------
// sonar_varredura_ctrl
//
// Sweep scheduler for the sonar. Walks the servo through N_POS angular
// positions in a ping-pong pattern (0 .. N_POS-1 .. 0). At every position it
// waits a settling interval, issues one measurement request to the sonar
// control unit and waits for that measurement to finish before moving on.
//
// Optional feature macro: VARREDURA_TIMEOUT_EN
//   defined   : AGUARDA gives up after TIMEOUT cycles without medida_pronto,
//               sets the sticky erro_timeout flag and skips the position.
//   undefined : AGUARDA waits indefinitely, erro_timeout is tied low and no
//               timeout counter exists.
//
// Ports
//   clock          in   1      system clock, rising edge
//   reset          in   1      asynchronous, active-high
//   ligar          in   1      level, sweep enabled
//   medida_pronto  in   1      sonar done pulse, only looked at in AGUARDA
//   req_medida     out  1      one-cycle measurement request (SOLICITA)
//   posicao        out  POS_W  current servo position index (registered)
//   sentido        out  1      1 = ascending, 0 = descending (registered)
//   ciclo_completo out  1      one-cycle pulse when posicao returns to 0
//   erro_timeout   out  1      sticky timeout flag
//   ocupado        out  1      high in every state except IDLE
//   db_estado      out  4      state code for the debug display
// ---------------------------------------------------------------------------
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE      0 | sweep stopped, position held, waiting for ligar
// POSICIONA 1 | servo settling at the current position
// SOLICITA  2 | single-cycle measurement request
// AGUARDA   3 | waiting for the sonar to report completion
// AVANCA    4 | one cycle: step position / direction for the next point
// (other)   F | illegal encoding, recovers to IDLE
// ---------------------------------------------------------------------------
module sonar_varredura_ctrl #(
   parameter int N_POS        = 8,
   parameter int POS_W        = 3,
   parameter int ASSENTAMENTO = 25_000_000,
   parameter int TIMEOUT      = 50_000_000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ligar,
   input  logic             medida_pronto,
   output logic             req_medida,
   output logic [POS_W-1:0] posicao,
   output logic             sentido,
   output logic             ciclo_completo,
   output logic             erro_timeout,
   output logic             ocupado,
   output logic [3:0]       db_estado
);

   // Elaboration-time guard against parameter sets the position logic
   // cannot represent.
   if (N_POS < 2 || POS_W < $clog2(N_POS) || ASSENTAMENTO < 1 || TIMEOUT < 1) begin : g_param_check
      $error("sonar_varredura_ctrl: illegal parameter set");
   end

   localparam int CNT_W = (ASSENTAMENTO > 1) ? $clog2(ASSENTAMENTO + 1) : 1;

   localparam logic [POS_W-1:0] POS_ZERO = '0;
   localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
   localparam logic [POS_W-1:0] POS_MAX  = POS_W'(N_POS - 1);
   localparam logic [POS_W-1:0] POS_PEN  = POS_W'(N_POS - 2);
   localparam logic [CNT_W-1:0] ASS_LAST = CNT_W'(ASSENTAMENTO - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_POSICIONA = 3'd1,
      S_SOLICITA  = 3'd2,
      S_AGUARDA   = 3'd3,
      S_AVANCA    = 3'd4
   } estado_t;

   estado_t          r_estado;
   estado_t          w_prox_estado;
   logic [CNT_W-1:0] r_cnt_assent;
   logic [POS_W-1:0] r_posicao;
   logic             r_sentido;
   logic             r_ciclo_completo;
   logic [POS_W-1:0] w_pos_prox;
   logic             w_sent_prox;
   logic             w_assent_fim;
   logic             w_timeout;

   assign w_assent_fim = (r_cnt_assent == ASS_LAST);

   // ------------------------------------------------------------------------
   // Timeout watchdog for AGUARDA
   // ------------------------------------------------------------------------
`ifdef VARREDURA_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] r_cnt_timeout;
   logic            r_erro_timeout;

   // A completion arriving on the last allowed cycle takes priority, so the
   // timeout only fires when medida_pronto is low.
   assign w_timeout = (r_estado == S_AGUARDA) && !medida_pronto &&
                      (r_cnt_timeout == TO_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt_timeout  <= '0;
         r_erro_timeout <= 1'b0;
      end else begin
         if (r_estado == S_AGUARDA)
            r_cnt_timeout <= r_cnt_timeout + TO_W'(1);
         else
            r_cnt_timeout <= '0;
         if (w_timeout)
            r_erro_timeout <= 1'b1;
      end
   end

   assign erro_timeout = r_erro_timeout;
`else
   assign w_timeout    = 1'b0;
   assign erro_timeout = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_estado <= S_IDLE;
      else
         r_estado <= w_prox_estado;
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_prox_estado = S_IDLE;
      case (r_estado)
         S_IDLE: begin
            w_prox_estado = ligar ? S_POSICIONA : S_IDLE;
         end
         S_POSICIONA: begin
            if (!ligar)
               w_prox_estado = S_IDLE;
            else if (w_assent_fim)
               w_prox_estado = S_SOLICITA;
            else
               w_prox_estado = S_POSICIONA;
         end
         S_SOLICITA: begin
            w_prox_estado = S_AGUARDA;
         end
         S_AGUARDA: begin
            // ligar is deliberately ignored here: an outstanding measurement
            // is always allowed to complete.
            if (medida_pronto || w_timeout)
               w_prox_estado = S_AVANCA;
            else
               w_prox_estado = S_AGUARDA;
         end
         S_AVANCA: begin
            w_prox_estado = ligar ? S_POSICIONA : S_IDLE;
         end
         default: begin
            w_prox_estado = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: Moore outputs
   // ------------------------------------------------------------------------
   always_comb begin
      req_medida = 1'b0;
      ocupado    = 1'b1;
      db_estado  = 4'hF;
      case (r_estado)
         S_IDLE: begin
            ocupado   = 1'b0;
            db_estado = 4'h0;
         end
         S_POSICIONA: begin
            db_estado = 4'h1;
         end
         S_SOLICITA: begin
            req_medida = 1'b1;
            db_estado  = 4'h2;
         end
         S_AGUARDA: begin
            db_estado = 4'h3;
         end
         S_AVANCA: begin
            db_estado = 4'h4;
         end
         default: begin
            ocupado   = 1'b0;
            db_estado = 4'hF;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Settling counter: counts cycles spent in POSICIONA, cleared elsewhere so
   // every entry starts a fresh interval.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_cnt_assent <= '0;
      else if (r_estado == S_POSICIONA && !w_assent_fim)
         r_cnt_assent <= r_cnt_assent + CNT_W'(1);
      else
         r_cnt_assent <= '0;
   end

   // ------------------------------------------------------------------------
   // Ping-pong position step. The end points reflect instead of wrapping.
   // ------------------------------------------------------------------------
   always_comb begin
      w_pos_prox  = r_posicao;
      w_sent_prox = r_sentido;
      if (r_sentido) begin
         if (r_posicao >= POS_MAX) begin
            w_pos_prox  = POS_PEN;
            w_sent_prox = 1'b0;
         end else begin
            w_pos_prox = r_posicao + POS_ONE;
         end
      end else begin
         if (r_posicao == POS_ZERO) begin
            w_pos_prox  = POS_ONE;
            w_sent_prox = 1'b1;
         end else begin
            w_pos_prox = r_posicao - POS_ONE;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_posicao        <= '0;
         r_sentido        <= 1'b1;
         r_ciclo_completo <= 1'b0;
      end else begin
         r_ciclo_completo <= 1'b0;
         if (r_estado == S_AVANCA) begin
            r_posicao        <= w_pos_prox;
            r_sentido        <= w_sent_prox;
            r_ciclo_completo <= (w_pos_prox == POS_ZERO);
         end
      end
   end

   assign posicao        = r_posicao;
   assign sentido        = r_sentido;
   assign ciclo_completo = r_ciclo_completo;

endmodule

// File: tb/tb_sonar_varredura_ctrl.sv
// Directed bench for sonar_varredura_ctrl (N_POS=4, ASSENTAMENTO=4, TIMEOUT=10).
module tb_sonar_varredura_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       ligar;
   logic       medida_pronto;
   logic       req_medida;
   logic [1:0] posicao;
   logic       sentido;
   logic       ciclo_completo;
   logic       erro_timeout;
   logic       ocupado;
   logic [3:0] db_estado;

   int n_total = 0;
   int n_pass  = 0;
   int lat;
   int npulse;

   int exp_pos  [7] = '{1, 2, 3, 2, 1, 0, 1};
   int exp_sent [7] = '{1, 1, 1, 0, 0, 0, 1};
   int exp_cic  [7] = '{0, 0, 0, 0, 0, 1, 0};

   sonar_varredura_ctrl #(
      .N_POS        (4),
      .POS_W        (2),
      .ASSENTAMENTO (4),
      .TIMEOUT      (10)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .ligar          (ligar),
      .medida_pronto  (medida_pronto),
      .req_medida     (req_medida),
      .posicao        (posicao),
      .sentido        (sentido),
      .ciclo_completo (ciclo_completo),
      .erro_timeout   (erro_timeout),
      .ocupado        (ocupado),
      .db_estado      (db_estado)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
   endtask

   // Waits (bounded) for req_medida, counting negedges and ciclo_completo pulses.
   task automatic wait_req(output int l, output int np);
      l  = 0;
      np = 0;
      do begin
         @(negedge clock);
         l++;
         if (ciclo_completo === 1'b1) np++;
      end while (req_medida !== 1'b1 && l < 40);
      chk("req_seen", {31'd0, req_medida}, 32'd1);
   endtask

   task automatic pulse_pronto();
      medida_pronto = 1'b1;
      @(negedge clock);
      medida_pronto = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_posicao"}, {30'd0, posicao}, 32'd0);
      chk({tag, "_sentido"}, {31'd0, sentido}, 32'd1);
      chk({tag, "_req"},     {31'd0, req_medida}, 32'd0);
      chk({tag, "_ciclo"},   {31'd0, ciclo_completo}, 32'd0);
      chk({tag, "_erro"},    {31'd0, erro_timeout}, 32'd0);
      chk({tag, "_ocupado"}, {31'd0, ocupado}, 32'd0);
      chk({tag, "_db"},      {28'd0, db_estado}, 32'd0);
   endtask

   initial begin
      reset         = 1'b1;
      ligar         = 1'b0;
      medida_pronto = 1'b0;
      repeat (2) @(negedge clock);
      chk_reset_vals("rst");
      reset = 1'b0;
      @(negedge clock);
      chk("idle_hold_db", {28'd0, db_estado}, 32'd0);

      // 1: start latency
      ligar = 1'b1;
      wait_req(lat, npulse);
      chk("first_latency", lat, 32'd5);
      chk("first_pos", {30'd0, posicao}, 32'd0);
      chk("first_ocupado", {31'd0, ocupado}, 32'd1);
      chk("first_db", {28'd0, db_estado}, 32'd2);

      // 2: ping-pong sweep
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         chk("req_one_cycle", {31'd0, req_medida}, 32'd0);
         chk("aguarda_db", {28'd0, db_estado}, 32'd3);
         pulse_pronto();
         chk("avanca_db", {28'd0, db_estado}, 32'd4);
         wait_req(lat, npulse);
         chk("step_latency", lat, 32'd5);
         chk("step_pos", {30'd0, posicao}, exp_pos[i]);
         chk("step_sentido", {31'd0, sentido}, exp_sent[i]);
         chk("step_ciclo", npulse, exp_cic[i]);
      end

      // 3: pronto only during SOLICITA is ignored
      medida_pronto = 1'b1;
      @(negedge clock);
      medida_pronto = 1'b0;
      chk("early_pronto_db", {28'd0, db_estado}, 32'd3);
      repeat (3) @(negedge clock);
      chk("early_pronto_db2", {28'd0, db_estado}, 32'd3);
      chk("early_pronto_pos", {30'd0, posicao}, 32'd1);

      // 4b: ligar drop in AGUARDA waits for completion
      ligar = 1'b0;
      repeat (2) @(negedge clock);
      chk("stop_aguarda_db", {28'd0, db_estado}, 32'd3);
      chk("stop_aguarda_ocup", {31'd0, ocupado}, 32'd1);
      pulse_pronto();
      chk("stop_avanca_db", {28'd0, db_estado}, 32'd4);
      @(negedge clock);
      chk("stop_idle_db", {28'd0, db_estado}, 32'd0);
      chk("stop_idle_pos", {30'd0, posicao}, 32'd2);
      chk("stop_idle_ocup", {31'd0, ocupado}, 32'd0);

      // 4a: ligar drop in POSICIONA aborts immediately
      ligar = 1'b1;
      @(negedge clock);
      chk("abort_posiciona_db", {28'd0, db_estado}, 32'd1);
      @(negedge clock);
      ligar = 1'b0;
      @(negedge clock);
      chk("abort_idle_db", {28'd0, db_estado}, 32'd0);
      chk("abort_idle_pos", {30'd0, posicao}, 32'd2);

      // 5: no completion
      ligar = 1'b1;
      wait_req(lat, npulse);
      chk("restart_latency", lat, 32'd5);
      chk("restart_pos", {30'd0, posicao}, 32'd2);
`ifdef VARREDURA_TIMEOUT_EN
      repeat (10) @(negedge clock);
      chk("to_before_db", {28'd0, db_estado}, 32'd3);
      chk("to_before_erro", {31'd0, erro_timeout}, 32'd0);
      @(negedge clock);
      chk("to_db", {28'd0, db_estado}, 32'd4);
      chk("to_erro", {31'd0, erro_timeout}, 32'd1);
      @(negedge clock);
      chk("to_pos", {30'd0, posicao}, 32'd3);
      chk("to_erro_sticky", {31'd0, erro_timeout}, 32'd1);
      wait_req(lat, npulse);
      chk("to_req_pos", {30'd0, posicao}, 32'd3);
      @(negedge clock);
      pulse_pronto();
      wait_req(lat, npulse);
      chk("to_back_pos", {30'd0, posicao}, 32'd2);
      @(negedge clock);
`else
      repeat (15) @(negedge clock);
      chk("noto_db", {28'd0, db_estado}, 32'd3);
      chk("noto_erro", {31'd0, erro_timeout}, 32'd0);
      chk("noto_pos", {30'd0, posicao}, 32'd2);
`endif

      // 6: asynchronous reset mid-operation
      chk("pre_rst_db", {28'd0, db_estado}, 32'd3);
      chk("pre_rst_pos", {30'd0, posicao}, 32'd2);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      @(negedge clock);
      reset = 1'b0;
      ligar = 1'b0;
      @(negedge clock);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
